nn_load_ctrl: RTL

Load sequencer that fills the accelerator's image buffer or weight memory from the 16-bit DMA read port. It issues one DMA read address per cycle, packs returned words into destination rows and emits one write strobe per completed row. Rows are 48 bits (3 words) for the image buffer and 288 bits (18 words) for the weight memory. It sits in `nn` between the DMA interface and the `nn_img_bf` / PE weight-memory write ports, and is started by the layer FSM.

---
 rtl/nn_load_ctrl.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/nn_load_ctrl.sv
// nn_load_ctrl: streams DMA words into image-buffer (3-word) or weight-memory (18-word) rows.
// Build option NN_LOAD_CTRL_BYTE_SWAP_EN swaps the two bytes of every DMA word before packing.
module nn_load_ctrl #(
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned DMA_ADDR_WIDTH  = 10,
  parameter int unsigned IMEM_ADDR_WIDTH = 10,
  parameter int unsigned IMEM_DATA_WIDTH = 48,
  parameter int unsigned WMEM_ADDR_WIDTH = 7,
  parameter int unsigned TOTAL_IN_WIDTH  = 288
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_start,
  input  logic                       i_sel,
  input  logic [DMA_ADDR_WIDTH-1:0]  i_src_base,
  input  logic [IMEM_ADDR_WIDTH-1:0] i_dst_base,
  input  logic [IMEM_ADDR_WIDTH-1:0] i_len,
  input  logic [2*DATA_WIDTH-1:0]    i_dma_rd_data,
  output logic [DMA_ADDR_WIDTH-1:0]  o_dma_rd_addr,
  output logic                       o_img_bf_wr_en,
  output logic [IMEM_ADDR_WIDTH-1:0] o_img_bf_wr_addr,
  output logic [IMEM_DATA_WIDTH-1:0] o_img_bf_wr_data,
  output logic                       o_wmem_wr_en,
  output logic [WMEM_ADDR_WIDTH-1:0] o_wmem_wr_addr,
  output logic [TOTAL_IN_WIDTH-1:0]  o_wmem_wr_data,
  output logic                       o_busy,
  output logic                       o_done
);

  localparam int unsigned WORD_W = 2 * DATA_WIDTH;
  localparam int unsigned CNT_W  = IMEM_ADDR_WIDTH + 5;
  localparam int unsigned K_W    = 5;
  localparam int unsigned W_IMG  = 3;
  localparam int unsigned W_WGT  = 18;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t                      state_q, state_d;
  logic                        sel_q, sel_d;
  logic [IMEM_ADDR_WIDTH-1:0]  dst_q, dst_d;
  logic [CNT_W-1:0]            total_q, total_d;
  logic [CNT_W-1:0]            n_q, n_d;
  logic [DMA_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                        rd_vld_q, rd_vld_d;
  logic                        drain_q, drain_d;
  logic [K_W-1:0]              cap_k_q, cap_k_d;
  logic [IMEM_ADDR_WIDTH-1:0]  cap_r_q, cap_r_d;
  logic [TOTAL_IN_WIDTH-1:0]   row_q, row_d;
  logic                        img_en_q, img_en_d;
  logic [IMEM_ADDR_WIDTH-1:0]  img_addr_q, img_addr_d;
  logic [IMEM_DATA_WIDTH-1:0]  img_data_q, img_data_d;
  logic                        wmem_en_q, wmem_en_d;
  logic [WMEM_ADDR_WIDTH-1:0]  wmem_addr_q, wmem_addr_d;
  logic [TOTAL_IN_WIDTH-1:0]   wmem_data_q, wmem_data_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic [WORD_W-1:0]           word_c;
  logic [K_W-1:0]              k_last;

`ifdef NN_LOAD_CTRL_BYTE_SWAP_EN
  assign word_c = {i_dma_rd_data[DATA_WIDTH-1:0], i_dma_rd_data[WORD_W-1:DATA_WIDTH]};
`else
  assign word_c = i_dma_rd_data;
`endif

  assign k_last = sel_q ? K_W'(W_WGT - 1) : K_W'(W_IMG - 1);

  // Issue side (addresses) and capture side (packing/writes) run one cycle apart.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    dst_d       = dst_q;
    total_d     = total_q;
    n_d         = n_q;
    addr_d      = addr_q;
    rd_vld_d    = 1'b0;
    drain_d     = drain_q;
    cap_k_d     = cap_k_q;
    cap_r_d     = cap_r_q;
    row_d       = row_q;
    img_en_d    = 1'b0;
    img_addr_d  = img_addr_q;
    img_data_d  = img_data_q;
    wmem_en_d   = 1'b0;
    wmem_addr_d = wmem_addr_q;
    wmem_data_d = wmem_data_q;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          if (i_len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = S_RUN;
            sel_d   = i_sel;
            dst_d   = i_dst_base;
            addr_d  = i_src_base;
            total_d = i_sel ? CNT_W'(i_len) * CNT_W'(W_WGT) : CNT_W'(i_len) * CNT_W'(W_IMG);
            n_d     = '0;
            cap_k_d = '0;
            cap_r_d = '0;
          end
        end
      end
      S_RUN: begin
        rd_vld_d = 1'b1;
        if (n_q == total_q - CNT_W'(1)) begin
          state_d = S_DRAIN;
          drain_d = 1'b0;
        end else begin
          n_d    = n_q + CNT_W'(1);
          addr_d = addr_q + DMA_ADDR_WIDTH'(1);
        end
      end
      S_DRAIN: begin
        // First cycle captures the last word, second cycle carries the last write.
        drain_d = 1'b1;
        if (drain_q) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (rd_vld_q) begin
      row_d[{cap_k_q, 4'b0000} +: WORD_W] = word_c;
      if (cap_k_q == k_last) begin
        cap_k_d = '0;
        cap_r_d = cap_r_q + IMEM_ADDR_WIDTH'(1);
        if (sel_q) begin
          wmem_en_d   = 1'b1;
          wmem_addr_d = WMEM_ADDR_WIDTH'(dst_q + cap_r_q);
          wmem_data_d = row_d;
        end else begin
          img_en_d    = 1'b1;
          img_addr_d  = dst_q + cap_r_q;
          img_data_d  = row_d[IMEM_DATA_WIDTH-1:0];
        end
      end else begin
        cap_k_d = cap_k_q + K_W'(1);
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      sel_q       <= 1'b0;
      dst_q       <= '0;
      total_q     <= '0;
      n_q         <= '0;
      addr_q      <= '0;
      rd_vld_q    <= 1'b0;
      drain_q     <= 1'b0;
      cap_k_q     <= '0;
      cap_r_q     <= '0;
      row_q       <= '0;
      img_en_q    <= 1'b0;
      img_addr_q  <= '0;
      img_data_q  <= '0;
      wmem_en_q   <= 1'b0;
      wmem_addr_q <= '0;
      wmem_data_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      dst_q       <= dst_d;
      total_q     <= total_d;
      n_q         <= n_d;
      addr_q      <= addr_d;
      rd_vld_q    <= rd_vld_d;
      drain_q     <= drain_d;
      cap_k_q     <= cap_k_d;
      cap_r_q     <= cap_r_d;
      row_q       <= row_d;
      img_en_q    <= img_en_d;
      img_addr_q  <= img_addr_d;
      img_data_q  <= img_data_d;
      wmem_en_q   <= wmem_en_d;
      wmem_addr_q <= wmem_addr_d;
      wmem_data_q <= wmem_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign o_dma_rd_addr    = addr_q;
  assign o_img_bf_wr_en   = img_en_q;
  assign o_img_bf_wr_addr = img_addr_q;
  assign o_img_bf_wr_data = img_data_q;
  assign o_wmem_wr_en     = wmem_en_q;
  assign o_wmem_wr_addr   = wmem_addr_q;
  assign o_wmem_wr_data   = wmem_data_q;
  assign o_busy           = busy_q;
  assign o_done           = done_q;

endmodule
